// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-256 round sequencer.
// Round count, index width and the controller state encoding live here.
package aes_pkg;

  localparam int N_ROUNDS = 14;
  localparam int CNT_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAITKEY,
    INIT,
    ROUND,
    FINAL,
    HOLD
  } rctrl_state_t;

  typedef logic [CNT_W-1:0] round_idx_t;

  // Index at which the demux steers the state to the output register.
  localparam round_idx_t LAST_IDX      = round_idx_t'(N_ROUNDS);
  localparam round_idx_t PRE_FINAL_IDX = round_idx_t'(N_ROUNDS - 1);

  // States in which the round datapath register is clocked.
  function automatic logic rounds_active(input rctrl_state_t s);
    return (s == INIT) || (s == ROUND) || (s == FINAL);
  endfunction

endpackage

// File: rtl/mod_round_cnt.sv
// Round index counter: clear, load and enabled increment, saturating at N_ROUNDS.
// Clear has priority over load, load over increment.
module mod_round_cnt
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_load,
  input  round_idx_t i_load_val,
  input  logic       i_en,
  output round_idx_t o_cnt,
  output logic       o_pre_final
);

  round_idx_t r_cnt;
  round_idx_t w_load_sat;

  // A load request beyond the last round is clamped so the index never wraps.
  assign w_load_sat = (i_load_val > LAST_IDX) ? LAST_IDX : i_load_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= w_load_sat;
    end else if (i_en && (r_cnt < LAST_IDX)) begin
      r_cnt <= r_cnt + round_idx_t'(1);
    end
  end

  assign o_cnt       = r_cnt;
  assign o_pre_final = (r_cnt == PRE_FINAL_IDX);

endmodule

// File: rtl/mod_round_ctrl.sv
// AES-256 iterative round sequencer: accepts a block, waits for the key schedule,
// steps the round index 0..N_ROUNDS and holds the finished block until taken.
module mod_round_ctrl
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             key_ready,
  input  logic             abort,
  output logic [CNT_W-1:0] addr,
  output logic             load_sel,
  output logic             round_en,
  output logic             skip_mix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  rctrl_state_t r_state;
  rctrl_state_t w_nxt;

  logic       w_cnt_clr;
  logic       w_cnt_load;
  logic       w_cnt_en;
  round_idx_t w_cnt;
  logic       w_pre_final;

  logic r_in_ready;
  logic r_load_sel;
  logic r_round_en;
  logic r_skip_mix;
  logic r_out_valid;
  logic r_busy;

  mod_round_cnt u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_cnt_clr),
    .i_load      (w_cnt_load),
    .i_load_val  (LAST_IDX),
    .i_en        (w_cnt_en),
    .o_cnt       (w_cnt),
    .o_pre_final (w_pre_final)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Abort cancels anything before HOLD; a finished block is always delivered.
  always_comb begin
    w_nxt      = r_state;
    w_cnt_clr  = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_en   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (in_valid && r_in_ready) begin
          w_nxt = WAITKEY;
        end
      end
      WAITKEY: begin
        if (abort) begin
          w_nxt     = IDLE;
          w_cnt_clr = 1'b1;
        end else if (key_ready) begin
          w_nxt     = INIT;
          w_cnt_clr = 1'b1;
        end
      end
      INIT: begin
        if (abort) begin
          w_nxt     = IDLE;
          w_cnt_clr = 1'b1;
        end else begin
          w_nxt    = ROUND;
          w_cnt_en = 1'b1;
        end
      end
      ROUND: begin
        if (abort) begin
          w_nxt     = IDLE;
          w_cnt_clr = 1'b1;
        end else if (w_pre_final) begin
          w_nxt      = FINAL;
          w_cnt_load = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      FINAL: begin
        if (abort) begin
          w_nxt     = IDLE;
          w_cnt_clr = 1'b1;
        end else begin
          w_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_nxt     = IDLE;
          w_cnt_clr = 1'b1;
        end
      end
      default: begin
        w_nxt     = IDLE;
        w_cnt_clr = 1'b1;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_load_sel  <= 1'b0;
      r_round_en  <= 1'b0;
      r_skip_mix  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_nxt == IDLE);
      r_load_sel  <= (w_nxt == INIT);
      r_round_en  <= rounds_active(w_nxt);
      r_skip_mix  <= (w_nxt == FINAL);
      r_out_valid <= (w_nxt == HOLD);
      r_busy      <= (w_nxt != IDLE);
    end
  end

  assign in_ready  = r_in_ready;
  assign addr      = w_cnt;
  assign load_sel  = r_load_sel;
  assign round_en  = r_round_en;
  assign skip_mix  = r_skip_mix;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mod_round_ctrl.sv
// Bench for mod_round_ctrl: directed scenarios then random traffic against a block-level model.
module tb_mod_round_ctrl;

  localparam int NR = 14;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       key_ready;
  logic       abort;
  logic [3:0] addr;
  logic       load_sel;
  logic       round_en;
  logic       skip_mix;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  always #5 clk = ~clk;

  mod_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_ready (key_ready),
    .abort     (abort),
    .addr      (addr),
    .load_sel  (load_sel),
    .round_en  (round_en),
    .skip_mix  (skip_mix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Block-level model: a block is pending, then waiting for its key, then m_t
  // counts edges since the key was taken (0 = initial AddRoundKey, NR = last round).
  bit m_active = 1'b0;
  bit m_keyed  = 1'b0;
  bit m_fresh  = 1'b1;
  int m_t      = 0;

  int  acc_cyc = 0;
  int  ov_cyc  = 0;
  int  ov_cnt  = 0;
  bit  prev_ov = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit run;
    int ea;
    run = m_active && m_keyed;
    ea  = run ? ((m_t < NR) ? m_t : NR) : 0;
    chk("in_ready",  8'(!m_active && !m_fresh), 8'(in_ready));
    chk("busy",      8'(busy),      8'(m_active));
    chk("addr",      8'(addr),      8'(ea));
    chk("load_sel",  8'(load_sel),  8'(run && (m_t == 0)));
    chk("round_en",  8'(round_en),  8'(run && (m_t <= NR)));
    chk("skip_mix",  8'(skip_mix),  8'(run && (m_t == NR)));
    chk("out_valid", 8'(out_valid), 8'(run && (m_t > NR)));
  endtask

  task automatic model_edge(input bit iv, input bit kr, input bit ab, input bit ordy);
    bit was_fresh;
    was_fresh = m_fresh;
    m_fresh   = 1'b0;
    if (!m_active) begin
      if (iv && !was_fresh) begin
        m_active = 1'b1;
        m_keyed  = 1'b0;
        m_t      = 0;
        acc_cyc  = cyc;
      end
    end else if (!m_keyed) begin
      if (ab) m_active = 1'b0;
      else if (kr) begin
        m_keyed = 1'b1;
        m_t     = 0;
      end
    end else if (m_t <= NR) begin
      if (ab) m_active = 1'b0;
      else m_t++;
    end else if (ordy) begin
      m_active = 1'b0;
    end
  endtask

  task automatic step(input bit iv, input bit kr, input bit ab, input bit ordy);
    in_valid  = iv;
    key_ready = kr;
    abort     = ab;
    out_ready = ordy;
    @(posedge clk);
    cyc++;
    model_edge(iv, kr, ab, ordy);
    #1;
    check_outputs();
    if (out_valid === 1'b1 && !prev_ov) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
    prev_ov = (out_valid === 1'b1);
  endtask

  task automatic wait_ov(input bit kr, input bit ordy);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step(1'b0, kr, 1'b0, ordy);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("wait_out_valid", 8'(seen), 8'd1);
  endtask

  task automatic wait_addr(input logic [3:0] target);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      if (addr === target) seen = 1'b1;
    end
    chk("wait_addr", 8'(seen), 8'd1);
  endtask

  initial begin
    int base;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    key_ready = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    #12;
    check_outputs();
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_in_ready", 8'(in_ready), 8'd1);

    // nominal block
    step(1'b1, 1'b1, 1'b0, 1'b1);
    wait_ov(1'b1, 1'b1);
    chk("latency_nominal", 8'(ov_cyc - acc_cyc), 8'd16);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("out_valid_one_cycle", 8'(out_valid), 8'd0);

    // key stall of 5 cycles
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1);
    wait_ov(1'b1, 1'b1);
    chk("latency_key_stall", 8'(ov_cyc - acc_cyc), 8'd21);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // backpressure in HOLD with a new block waiting
    step(1'b1, 1'b1, 1'b0, 1'b0);
    wait_ov(1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("hold_addr", 8'(addr), 8'(NR));
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("accept_after_hold", 8'(busy), 8'd1);

    // abort in ROUND at addr 9
    wait_addr(4'd9);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("abort_addr", 8'(addr), 8'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // abort in HOLD is ignored
    step(1'b1, 1'b1, 1'b0, 1'b0);
    wait_ov(1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("abort_in_hold", 8'(out_valid), 8'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // abort with in_valid in IDLE accepts, abort in WAITKEY cancels
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // asynchronous reset mid-round
    step(1'b1, 1'b1, 1'b0, 1'b1);
    wait_addr(4'd7);
    #2;
    rst_n = 1'b0;
    #1;
    m_active = 1'b0;
    m_keyed  = 1'b0;
    m_fresh  = 1'b1;
    prev_ov  = 1'b0;
    check_outputs();
    #3;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_release_addr", 8'(addr), 8'd0);

    // back-to-back with in_valid held
    base = ov_cnt;
    repeat (56) step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("b2b_pulses", 8'(ov_cnt - base), 8'd3);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
